// File: rtl/ram_master.sv
// Burst master for a single-port synchronous RAM: word-by-word write bursts
// with pass-through data and read bursts buffered through a 2-entry output FIFO.
module ram_master #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 12,
   parameter int LEN_W  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LEN_W-1:0]  req_len,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_last,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   output logic              ram_re,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  iss_q, iss_d;
   logic [LEN_W-1:0]  out_q, out_d;
   logic              inflight_q, inflight_d;
   logic              done_q, done_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              wptr_q, wptr_d;
   logic              rptr_q, rptr_d;
   logic [DATA_W-1:0] mem_q [2];

   logic       pop;
   logic       push;
   logic       issue;
   logic       we;
   logic [2:0] occ;

   assign pop   = (cnt_q != 2'd0) && rd_ready;
   assign push  = inflight_q;
   // Occupancy after this cycle's pop, counting the word still on the RAM bus.
   assign occ   = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue = (state_q == READ) && (occ < 3'd2);
   assign we    = (state_q == WRITE) && wr_valid;

   // The done cycle is already IDLE but must not accept a new request.
   assign req_ready = (state_q == IDLE) && !done_q;
   assign wr_ready  = (state_q == WRITE);
   assign ram_we    = we;
   assign ram_re    = issue;
   assign ram_addr  = ((state_q == WRITE) || (state_q == READ)) ? addr_q : '0;
   assign ram_wdata = we ? wr_data : '0;
   assign rd_valid  = (cnt_q != 2'd0);
   assign rd_data   = rd_valid ? mem_q[rptr_q] : '0;
   assign rd_last   = rd_valid && (out_q == len_q);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      len_d      = len_q;
      iss_d      = iss_q;
      out_d      = out_q;
      done_d     = 1'b0;
      inflight_d = issue;
      cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
      wptr_d     = wptr_q ^ push;
      rptr_d     = rptr_q ^ pop;
      if (pop) begin
         out_d = out_q + LEN_W'(1);
      end
      case (state_q)
         IDLE: begin
            if (req_valid && req_ready) begin
               addr_d  = req_addr;
               len_d   = req_len;
               iss_d   = '0;
               out_d   = '0;
               state_d = req_write ? WRITE : READ;
            end
         end
         WRITE: begin
            if (we) begin
               addr_d = addr_q + ADDR_W'(1);
               if (iss_q == len_q) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end else begin
                  iss_d = iss_q + LEN_W'(1);
               end
            end
         end
         READ: begin
            if (issue) begin
               addr_d = addr_q + ADDR_W'(1);
               if (iss_q == len_q) begin
                  state_d = DRAIN;
               end else begin
                  iss_d = iss_q + LEN_W'(1);
               end
            end
         end
         DRAIN: begin
            if ((cnt_q == 2'd0) && !inflight_q) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         len_q      <= '0;
         iss_q      <= '0;
         out_q      <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= 2'd0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         iss_q      <= iss_d;
         out_q      <= out_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
      end
   end

   // FIFO storage is data only; a reset empties it through the pointers/count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= ram_rdata;
      end
   end

endmodule

// File: tb/tb_ram_master.sv
// Directed bench for ram_master with a behavioural synchronous RAM behind it.
module tb_ram_master;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [11:0] req_addr;
   logic [3:0]  req_len;
   logic        wr_valid;
   logic        wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid;
   logic        rd_ready;
   logic [15:0] rd_data;
   logic        rd_last;
   logic [11:0] ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic        ram_re;
   logic [15:0] ram_rdata;
   logic        busy;
   logic        done;

   int vectors;
   int miscompares;
   logic [15:0] exp_q [16];
   logic [15:0] ram [4096];

   ram_master dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_len   (req_len),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .wr_data   (wr_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_re    (ram_re),
      .ram_rdata (ram_rdata),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      if (ram_re) ram_rdata <= ram[ram_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_req_ready", req_ready, 1);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_last", rd_last, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_ram_we", ram_we, 0);
      check("rst_ram_re", ram_re, 0);
      check("rst_ram_addr", ram_addr, 0);
      check("rst_ram_wdata", ram_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
   endtask

   task automatic run_write(input logic [11:0] a, input logic [3:0] l,
                            input bit gap, input bit offer_next);
      int k;
      logic [11:0] ea;
      req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
      #1;
      check("wr_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      k = 0;
      ea = a;
      for (int cyc = 0; cyc < 64 && k <= int'(l); cyc++) begin
         wr_valid = !gap || (cyc % 2 == 0);
         wr_data  = exp_q[k];
         #1;
         check("wr_ready", wr_ready, 1);
         check("wr_busy", busy, 1);
         check("wr_we", ram_we, wr_valid);
         check("wr_addr", ram_addr, ea);
         check("wr_re_low", ram_re, 0);
         if (wr_valid) begin
            check("wr_wdata", ram_wdata, exp_q[k]);
            ea = ea + 12'd1;
            k++;
         end
         tick();
      end
      check("wr_words", k, int'(l) + 1);
      wr_valid = 1'b0;
      if (offer_next) begin
         req_valid = 1'b1; req_write = 1'b0; req_addr = 12'd10; req_len = 4'd0;
      end
      #1;
      check("wr_done", done, 1);
      check("wr_done_busy", busy, 0);
      check("wr_done_we", ram_we, 0);
      check("wr_done_wr_ready", wr_ready, 0);
      check("wr_done_req_ready", req_ready, 0);
      tick();
      check("wr_done_clear", done, 0);
      check("wr_idle_busy", busy, 0);
      check("wr_idle_req_ready", req_ready, 1);
   endtask

   task automatic run_read(input logic [11:0] a, input logic [3:0] l, input bit toggle);
      int issued;
      int popped;
      int done_cyc;
      bit seen_done;
      logic [11:0] ea;
      req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l; rd_ready = 1'b0;
      #1;
      check("rd_req_ready", req_ready, 1);
      tick();
      req_valid = 1'b0;
      issued = 0; popped = 0; done_cyc = -1; seen_done = 1'b0;
      ea = a;
      for (int cyc = 0; cyc < 100 && !seen_done; cyc++) begin
         rd_ready = !toggle || (cyc % 2 == 0);
         #1;
         check("rd_outstanding", (issued - popped) <= 2, 1);
         check("rd_we_re_excl", ram_we && ram_re, 0);
         if (ram_re) begin
            check("rd_issue_addr", ram_addr, ea);
            ea = ea + 12'd1;
            issued++;
         end
         if (rd_valid && rd_ready) begin
            check("rd_data", rd_data, exp_q[popped]);
            check("rd_last", rd_last, popped == int'(l));
            popped++;
         end
         if (done) begin
            seen_done = 1'b1;
            done_cyc = cyc;
            check("rd_done_busy", busy, 0);
            check("rd_done_valid", rd_valid, 0);
         end
         tick();
      end
      check("rd_issued", issued, int'(l) + 1);
      check("rd_popped", popped, int'(l) + 1);
      check("rd_done_seen", seen_done, 1);
      if (!toggle) check("rd_throughput", done_cyc, int'(l) + 4);
      check("rd_done_clear", done, 0);
      rd_ready = 1'b0;
   endtask

   initial begin
      int popped;
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
      wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

      tick();
      check_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("idle_req_ready", req_ready, 1);

      // single write, then a read offered in the done cycle
      exp_q[0] = 16'hAAAA;
      run_write(12'd10, 4'd0, 1'b0, 1'b1);
      run_read(12'd10, 4'd0, 1'b0);

      // wrap-around burst
      for (int i = 0; i < 4; i++) exp_q[i] = 16'(i + 1);
      run_write(12'hFFE, 4'd3, 1'b0, 1'b0);
      run_read(12'hFFE, 4'd3, 1'b0);

      // read backpressure
      for (int i = 0; i < 8; i++) exp_q[i] = 16'h5000 + 16'(i);
      run_write(12'd200, 4'd7, 1'b0, 1'b0);
      run_read(12'd200, 4'd7, 1'b1);

      // gapped write data
      for (int i = 0; i < 3; i++) exp_q[i] = 16'h7000 + 16'(i);
      run_write(12'd100, 4'd2, 1'b1, 1'b0);
      run_read(12'd100, 4'd2, 1'b0);

      // reset in the middle of a 16-word read
      for (int i = 0; i < 16; i++) exp_q[i] = 16'h9000 + 16'(i);
      run_write(12'd300, 4'd15, 1'b0, 1'b0);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 12'd300; req_len = 4'd15;
      tick();
      req_valid = 1'b0;
      rd_ready = 1'b1;
      popped = 0;
      for (int cyc = 0; cyc < 40 && popped < 5; cyc++) begin
         #1;
         if (rd_valid) begin
            check("mid_rd_data", rd_data, exp_q[popped]);
            popped++;
         end
         tick();
      end
      check("mid_popped", popped, 5);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      tick();
      check_reset();
      rst_n = 1'b1;
      tick();
      check("post_rst_done", done, 0);
      check("post_rst_rd_valid", rd_valid, 0);
      check("post_rst_busy", busy, 0);

      exp_q[0] = 16'hBEEF;
      run_write(12'd20, 4'd0, 1'b0, 1'b0);
      run_read(12'd20, 4'd0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ram_master.md
RAM_MASTER -- requirements
Module: ram_master

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all logic rising-edge.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: req_valid  input  1  burst request offered.
REQ-004 SHALL have: req_ready  output  1  request accepted when req_valid&&req_ready.
REQ-005 SHALL have: req_write  input  1  1=write burst, 0=read burst.
REQ-006 SHALL have: req_addr  input  12  start word address.
REQ-007 SHALL have: req_len  input  4  burst length minus one (0 -> 1 word, 15 -> 16 words).
REQ-008 SHALL have: wr_valid / wr_ready / wr_data  input / output / input  1/1/16  write-data stream.
REQ-009 SHALL have: rd_valid / rd_ready / rd_data / rd_last  output / input / output / output  1/1/16/1  read-data stream.
REQ-010 SHALL have: ram_addr  output  12, ram_wdata  output  16, ram_we  output  1, ram_re  output  1, ram_rdata  input  16  RAM port.
REQ-011 SHALL have: busy  output  1, done  output  1  (one-cycle pulse at burst end).

Function
REQ-012 SHALL assume the RAM port contract: write at the clk edge where ram_we=1; ram_rdata valid in the cycle after ram_re=1.
REQ-013 SHALL implement FSM states IDLE, WRITE, READ, DRAIN.
REQ-014 IDLE: req_ready=1; on accept, latch addr/len/dir, go to WRITE or READ next cycle; req_ready=0 in all other states.
REQ-015 WRITE: wr_ready=1; each cycle wr_valid=1 -> ram_we=1, ram_addr=current address, ram_wdata=wr_data, same cycle (combinational pass-through); wr_valid=0 -> ram_we=0, no progress.
REQ-016 WRITE: after word len+1 written, pulse done next cycle and return to IDLE.
REQ-017 READ: assert ram_re=1 for the current address only when (fifo_count + inflight - pop) < 2, where pop = rd_valid&&rd_ready; capture ram_rdata into a 2-entry output FIFO the cycle after issue.
REQ-018 READ: after len+1 reads issued, go to DRAIN; DRAIN waits until FIFO empty and nothing in flight, then pulses done and returns to IDLE.
REQ-019 rd_valid SHALL equal FIFO non-empty; rd_data = FIFO head; rd_last=1 only on the final word of the burst.
REQ-020 Back-to-back reads with rd_ready held 1 SHALL sustain one word per cycle.
REQ-021 Address SHALL increment by 1 per word issued, wrapping 12'hFFF -> 12'h000.
REQ-022 ram_we and ram_re SHALL never be 1 in the same cycle; both 0 in IDLE and DRAIN.
REQ-023 busy SHALL be 1 in every state except IDLE; done SHALL coincide with the IDLE-return transition and be 0 otherwise.
REQ-024 wr_ready SHALL be 0 outside WRITE; rd_valid SHALL be 0 outside READ/DRAIN.
REQ-025 A new request offered in the done cycle SHALL not be accepted until the following cycle (IDLE).

Reset
REQ-026 rst_n=0 sampled at a clk edge SHALL force IDLE, clear FIFO, in-flight flag, counters and address.
REQ-027 During and after reset: req_ready=1 (after first edge), wr_ready=0, rd_valid=0, rd_last=0, rd_data=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, busy=0, done=0.
REQ-028 Reset mid-burst SHALL abort the burst with no done pulse; words already written stay written; any in-flight read data is discarded.

Verification
REQ-029 Single write: addr=10, len=0, wr_data=16'hAAAA -> one cycle ram_we=1, ram_addr=10, ram_wdata=16'hAAAA; done pulses next cycle.
REQ-030 Single read after REQ-029: addr=10, len=0, rd_ready=1 -> ram_re=1 once; rd_data=16'hAAAA with rd_last=1 two cycles after accept; done follows.
REQ-031 Wrap burst: write addr=12'hFFE, len=3, data 1..4 -> ram_addr sequence FFE, FFF, 000, 001; readback returns 1,2,3,4 with rd_last on 4.
REQ-032 Backpressure: read len=7 with rd_ready toggling 1/0 -> no word lost or duplicated, FIFO never exceeds 2, ram_re stalls correctly.
REQ-033 Write stall: wr_valid gapped -> ram_we only on wr_valid cycles, address advances only then.
REQ-034 Reset mid read len=15 after 5 words -> all outputs to reset values next edge, no done, next request accepted normally.
